// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: divider operation encoding, width and FSM states.
package ex_pkg;

  localparam int DIV_WIDTH = 32;

  // Operation encoding shared with the EX decoder.
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // True for the signed flavours (DIV, REM).
  function automatic logic is_signed_op(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor from the widened partial remainder and keep the difference if it
// did not borrow.
module div_step
  import ex_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // The partial remainder is one bit wider than the operands, so a divisor of
  // 2^(WIDTH-1) or more cannot overflow the trial subtraction.
  assign shifted_s = {rem, quo[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};

  // Keep the difference when no borrow occurred and record a 1 quotient bit.
  always_comb begin
    rem_next = shifted_s[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_next = diff_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in the
// accept cycle without entering CALC.
module divider
  import ex_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  div_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic [WIDTH-1:0] rem_r, rem_next_s;
  logic [WIDTH-1:0] quo_r, quo_next_s;
  logic [WIDTH-1:0] dvsr_r, dvsr_next_s;
  div_op_e          op_r, op_next_s;
  logic             neg_quo_r, neg_quo_next_s;
  logic             neg_rem_r, neg_rem_next_s;
  logic [WIDTH-1:0] result_r, result_next_s;
  logic             done_r, done_next_s;
  logic             busy_r, busy_next_s;

  div_op_e          mode_s;
  logic             signed_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;
  logic [WIDTH-1:0] quo_fixed_s;
  logic [WIDTH-1:0] rem_fixed_s;

  assign mode_s   = div_op_e'(mode);
  assign signed_s = is_signed_op(mode_s);
  assign sign_a_s = signed_s & dividend[WIDTH-1];
  assign sign_b_s = signed_s & divisor[WIDTH-1];

  // Sign fix-up applied at FINISH to the unsigned magnitude results.
  assign quo_fixed_s = neg_quo_r ? (-quo_r) : quo_r;
  assign rem_fixed_s = neg_rem_r ? (-rem_r) : rem_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next_s   = state_r;
    count_next_s   = count_r;
    rem_next_s     = rem_r;
    quo_next_s     = quo_r;
    dvsr_next_s    = dvsr_r;
    op_next_s      = op_r;
    neg_quo_next_s = neg_quo_r;
    neg_rem_next_s = neg_rem_r;
    result_next_s  = result_r;
    done_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor == ALL_ZEROS) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            result_next_s = ((mode_s == DIV) || (mode_s == DIVU)) ? ALL_ONES : dividend;
            done_next_s   = 1'b1;
          end else if (signed_s && (dividend == MIN_NEG) && (divisor == ALL_ONES)) begin
            // Signed overflow: quotient wraps to MIN_NEG, remainder is zero.
            result_next_s = (mode_s == DIV) ? MIN_NEG : ALL_ZEROS;
            done_next_s   = 1'b1;
          end else begin
            op_next_s      = mode_s;
            neg_quo_next_s = sign_a_s ^ sign_b_s;
            neg_rem_next_s = sign_a_s;
            rem_next_s     = ALL_ZEROS;
            quo_next_s     = sign_a_s ? (-dividend) : dividend;
            dvsr_next_s    = sign_b_s ? (-divisor) : divisor;
            count_next_s   = CNT_LAST;
            state_next_s   = CALC;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        rem_next_s   = step_rem_s;
        quo_next_s   = step_quo_s;
        count_next_s = count_r - CNT_ONE;
        if (count_r == CNT_ZERO) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = CALC;
        end
      end
      FINISH: begin
        case (op_r)
          DIV, DIVU: result_next_s = quo_fixed_s;
          REM, REMU: result_next_s = rem_fixed_s;
          default:   result_next_s = quo_fixed_s;
        endcase
        done_next_s  = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State, datapath and output registers; async reset aborts any operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      count_r   <= CNT_ZERO;
      rem_r     <= ALL_ZEROS;
      quo_r     <= ALL_ZEROS;
      dvsr_r    <= ALL_ZEROS;
      op_r      <= DIV;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_r  <= ALL_ZEROS;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      count_r   <= count_next_s;
      rem_r     <= rem_next_s;
      quo_r     <= quo_next_s;
      dvsr_r    <= dvsr_next_s;
      op_r      <= op_next_s;
      neg_quo_r <= neg_quo_next_s;
      neg_rem_r <= neg_rem_next_s;
      result_r  <= result_next_s;
      done_r    <= done_next_s;
      busy_r    <= busy_next_s;
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the iterative divider.
module tb_divider;

  logic        clk;
  logic        reset;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  localparam logic [1:0] M_DIV  = 2'd0;
  localparam logic [1:0] M_DIVU = 2'd1;
  localparam logic [1:0] M_REM  = 2'd2;
  localparam logic [1:0] M_REMU = 2'd3;

  divider dut (
    .clk      (clk),
    .reset    (reset),
    .dividend (dividend),
    .divisor  (divisor),
    .start    (start),
    .mode     (mode),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for done; edges counts clock edges after the current one.
  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Issue one operation and wait for its completion (start dropped after accept).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        output logic [31:0] res, output int edges);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    mode     = m;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges);
    res = result;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = 32'h0;
    divisor = 32'h0;
    mode = M_DIV;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_divu;
    logic [31:0] res;
    int edges;
    run_op(32'hFFFF_FFFF, 32'h0000_0003, M_DIVU, res, edges);
    checks++;
    if (res !== 32'h5555_5555) begin failures++; $display("FAIL divu_result got=%h exp=%h", res, 32'h5555_5555); end
    checks++;
    if (edges !== 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", edges); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL divu_busy_in_done got=%b exp=0", busy); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL divu_done_pulse got=%b exp=0", done); end
    checks++;
    if (result !== 32'h5555_5555) begin failures++; $display("FAIL divu_result_hold got=%h exp=%h", result, 32'h5555_5555); end
  endtask

  task automatic test_signed;
    logic [31:0] va [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h0000_0007,
                            32'h0000_0007, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [7] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_1000, 32'hFFFF_FFFE,
                            32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [1:0]  vm [7] = '{M_DIV, M_REM, M_REMU, M_DIV, M_REM, M_DIVU, M_REMU};
    logic [31:0] ve [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0678, 32'hFFFF_FFFD,
                            32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] res;
    int edges;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vm[i], res, edges);
      checks++;
      if (res !== ve[i]) begin failures++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      checks++;
      if (edges !== 33) begin failures++; $display("FAIL signed_latency[%0d] got=%0d exp=33", i, edges); end
    end
  endtask

  task automatic test_div_zero;
    logic [1:0]  vm [4] = '{M_DIV, M_REMU, M_DIVU, M_REM};
    logic [31:0] ve [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] res;
    int edges;
    for (int i = 0; i < 4; i++) begin
      run_op(32'h1234_5678, 32'h0000_0000, vm[i], res, edges);
      checks++;
      if (res !== ve[i]) begin failures++; $display("FAIL divzero_result[%0d] got=%h exp=%h", i, res, ve[i]); end
      checks++;
      if (edges !== 0) begin failures++; $display("FAIL divzero_latency[%0d] got=%0d exp=0", i, edges); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] res;
    int edges;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, M_DIV, res, edges);
    checks++;
    if (res !== 32'h8000_0000) begin failures++; $display("FAIL ovf_div_result got=%h exp=%h", res, 32'h8000_0000); end
    checks++;
    if (edges !== 0) begin failures++; $display("FAIL ovf_div_latency got=%0d exp=0", edges); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, M_REM, res, edges);
    checks++;
    if (res !== 32'h0000_0000) begin failures++; $display("FAIL ovf_rem_result got=%h exp=%h", res, 32'h0); end
    checks++;
    if (edges !== 0) begin failures++; $display("FAIL ovf_rem_latency got=%0d exp=0", edges); end
  endtask

  task automatic test_busy_ignore;
    int edges;
    int extra_done;
    @(negedge clk);
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'h0000_0003;
    mode     = M_DIVU;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    @(negedge clk);
    dividend = 32'h0000_000A;
    divisor  = 32'h0000_0002;
    mode     = M_DIV;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    checks++;
    if (result !== 32'h5555_5555) begin failures++; $display("FAIL ignore_result got=%h exp=%h", result, 32'h5555_5555); end
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra_done); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res;
    int edges;
    // Start raised in the done cycle of the previous operation.
    run_op(32'hFFFF_FFFF, 32'h0000_0003, M_DIVU, res, edges);
    checks++;
    if (res !== 32'h5555_5555) begin failures++; $display("FAIL b2b_first got=%h exp=%h", res, 32'h5555_5555); end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    wait_done(edges);
    checks++;
    if (result !== 32'h5555_5555) begin failures++; $display("FAIL b2b_second got=%h exp=%h", result, 32'h5555_5555); end
    checks++;
    if (edges !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", edges); end
    // Start held high across completion; operands changed while busy.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    mode     = M_DIVU;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'h0000_0003;
    wait_done(edges);
    checks++;
    if (result !== 32'd14) begin failures++; $display("FAIL held_first got=%h exp=%h", result, 32'd14); end
    checks++;
    if (edges !== 33) begin failures++; $display("FAIL held_latency got=%0d exp=33", edges); end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL held_reaccept got=%b exp=1", busy); end
    wait_done(edges);
    checks++;
    if (result !== 32'h5555_5555) begin failures++; $display("FAIL held_second got=%h exp=%h", result, 32'h5555_5555); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] res;
    int edges;
    @(negedge clk);
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'h0000_0003;
    mode     = M_DIVU;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL midop_done got=%b exp=0", done); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL midop_result got=%h exp=%h", result, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd100, 32'd7, M_DIVU, res, edges);
    checks++;
    if (res !== 32'd14) begin failures++; $display("FAIL midop_next_result got=%h exp=%h", res, 32'd14); end
    checks++;
    if (edges !== 33) begin failures++; $display("FAIL midop_next_latency got=%0d exp=33", edges); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
